// File: rtl/selector_casillas.sv
// Cursor/selection for the 3x3 gato board: synchronized button edges move the cursor or mark a cell.
// Latency: SYNC_STAGES+1 clk edges from button rise to output change. No backpressure; one action per cycle.
// SELECTOR_WRAP_EN: when defined, cursor moves wrap around the board edges instead of saturating.
module selector_casillas #(
    parameter int SYNC_STAGES = 2,
    parameter int RESET_CELL  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       boton_arriba,
    input  logic       boton_abajo,
    input  logic       boton_izq,
    input  logic       boton_der,
    input  logic       boton_elige,
    input  logic       turno_p1,
    input  logic       nuevo_juego,
    output logic [3:0] p1_mm,
    output logic [3:0] p2_mm,
    output logic [3:0] cuadro,
    output logic       jugada_ok
);
`ifdef SELECTOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam logic [3:0] RST_CELL = 4'(RESET_CELL);
    localparam logic [3:0] NONE     = 4'hF;

    // Bit order sets priority: lowest index wins.
    localparam int B_ELIGE  = 0;
    localparam int B_ARRIBA = 1;
    localparam int B_ABAJO  = 2;
    localparam int B_IZQ    = 3;
    localparam int B_DER    = 4;

    logic [4:0] btn_raw;
    logic [4:0] sync_q [SYNC_STAGES];
    logic [4:0] prev_q;
    logic [4:0] btn_edge;

    logic [8:0] occ_q, occ_n;
    logic [3:0] cuadro_n, p1_n, p2_n;
    logic       ok_n;

    assign btn_raw  = {boton_der, boton_izq, boton_abajo, boton_arriba, boton_elige};
    assign btn_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

    function automatic logic [1:0] row_of(input logic [3:0] c);
        if (c < 4'd3)      return 2'd0;
        else if (c < 4'd6) return 2'd1;
        else               return 2'd2;
    endfunction

    function automatic logic [1:0] col_of(input logic [3:0] c);
        case (c)
            4'd0, 4'd3, 4'd6: return 2'd0;
            4'd1, 4'd4, 4'd7: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= btn_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        cuadro_n = cuadro;
        p1_n     = p1_mm;
        p2_n     = p2_mm;
        occ_n    = occ_q;
        ok_n     = 1'b0;
        if (nuevo_juego) begin
            cuadro_n = RST_CELL;
            p1_n     = NONE;
            p2_n     = NONE;
            occ_n    = '0;
        end else if (btn_edge[B_ELIGE]) begin
            // Occupied cell: selection silently ignored.
            if (!occ_q[cuadro]) begin
                occ_n[cuadro] = 1'b1;
                ok_n          = 1'b1;
                if (turno_p1) p1_n = cuadro;
                else          p2_n = cuadro;
            end
        end else if (btn_edge[B_ARRIBA]) begin
            if (row_of(cuadro) != 2'd0) cuadro_n = cuadro - 4'd3;
            else if (WRAP)              cuadro_n = cuadro + 4'd6;
        end else if (btn_edge[B_ABAJO]) begin
            if (row_of(cuadro) != 2'd2) cuadro_n = cuadro + 4'd3;
            else if (WRAP)              cuadro_n = cuadro - 4'd6;
        end else if (btn_edge[B_IZQ]) begin
            if (col_of(cuadro) != 2'd0) cuadro_n = cuadro - 4'd1;
            else if (WRAP)              cuadro_n = cuadro + 4'd2;
        end else if (btn_edge[B_DER]) begin
            if (col_of(cuadro) != 2'd2) cuadro_n = cuadro + 4'd1;
            else if (WRAP)              cuadro_n = cuadro - 4'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuadro    <= RST_CELL;
            p1_mm     <= NONE;
            p2_mm     <= NONE;
            occ_q     <= '0;
            jugada_ok <= 1'b0;
        end else begin
            cuadro    <= cuadro_n;
            p1_mm     <= p1_n;
            p2_mm     <= p2_n;
            occ_q     <= occ_n;
            jugada_ok <= ok_n;
        end
    end
endmodule

// File: tb/tb_selector_casillas.sv
// Directed bench for selector_casillas with an expected-state scoreboard.
module tb_selector_casillas;
`ifdef SELECTOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam int B_EL = 0, B_UP = 1, B_DN = 2, B_IZ = 3, B_DE = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic boton_arriba = 0, boton_abajo = 0, boton_izq = 0, boton_der = 0, boton_elige = 0;
    logic turno_p1 = 0, nuevo_juego = 0;
    logic [3:0] p1_mm, p2_mm, cuadro;
    logic jugada_ok;

    typedef struct {
        logic [3:0] cuadro;
        logic [3:0] p1;
        logic [3:0] p2;
        int         pulses;
    } exp_t;

    exp_t sb[$];
    int checks = 0, failures = 0, pulse_cnt = 0;
    logic [3:0] cur, e1, e2;
    int epulses;

    selector_casillas dut (
        .clk(clk), .rst_n(rst_n),
        .boton_arriba(boton_arriba), .boton_abajo(boton_abajo),
        .boton_izq(boton_izq), .boton_der(boton_der), .boton_elige(boton_elige),
        .turno_p1(turno_p1), .nuevo_juego(nuevo_juego),
        .p1_mm(p1_mm), .p2_mm(p2_mm), .cuadro(cuadro), .jugada_ok(jugada_ok)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (jugada_ok === 1'b1) pulse_cnt++;

    function automatic logic [3:0] mv(input logic [3:0] c, input int b);
        int r = int'(c) / 3;
        int k = int'(c) % 3;
        int n = int'(c);
        case (b)
            B_UP: if (r > 0) n = n - 3; else if (WRAP) n = n + 6;
            B_DN: if (r < 2) n = n + 3; else if (WRAP) n = n - 6;
            B_IZ: if (k > 0) n = n - 1; else if (WRAP) n = n + 2;
            B_DE: if (k < 2) n = n + 1; else if (WRAP) n = n - 2;
            default: ;
        endcase
        return 4'(n);
    endfunction

    task automatic set_btns(input logic [4:0] v);
        boton_elige  = v[B_EL];
        boton_arriba = v[B_UP];
        boton_abajo  = v[B_DN];
        boton_izq    = v[B_IZ];
        boton_der    = v[B_DE];
    endtask

    task automatic press(input logic [4:0] v, input int hold);
        @(negedge clk);
        set_btns(v);
        repeat (hold) @(negedge clk);
        set_btns(5'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic push_exp();
        exp_t e;
        e.cuadro = cur; e.p1 = e1; e.p2 = e2; e.pulses = epulses;
        sb.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; failures++;
            $error("FAIL %s scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (cuadro === e.cuadro) else begin
            failures++; $error("FAIL %s cuadro got=%0d exp=%0d", tag, cuadro, e.cuadro);
        end
        checks++;
        assert (p1_mm === e.p1) else begin
            failures++; $error("FAIL %s p1_mm got=%0h exp=%0h", tag, p1_mm, e.p1);
        end
        checks++;
        assert (p2_mm === e.p2) else begin
            failures++; $error("FAIL %s p2_mm got=%0h exp=%0h", tag, p2_mm, e.p2);
        end
        checks++;
        assert (pulse_cnt === e.pulses) else begin
            failures++; $error("FAIL %s jugada_ok cycles got=%0d exp=%0d", tag, pulse_cnt, e.pulses);
        end
    endtask

    task automatic move(input int b, input string tag);
        logic [4:0] v;
        v = '0;
        v[b] = 1'b1;
        press(v, 4);
        cur = mv(cur, b);
        push_exp();
        check(tag);
    endtask

    task automatic elige(input logic t, input logic accept, input string tag);
        turno_p1 = t;
        press(5'b00001, 4);
        if (accept) begin
            epulses++;
            if (t) e1 = cur; else e2 = cur;
        end
        push_exp();
        check(tag);
    endtask

    task automatic expect_reset_state();
        cur = 4'd4; e1 = 4'hF; e2 = 4'hF;
    endtask

    int          seq_b [6] = '{B_DN, B_IZ, B_DN, B_DE, B_DE, B_UP};
    logic [3:0]  seq_c [6] = '{4'd4, 4'd3, 4'd6, 4'd7, 4'd8, 4'd5};
    int          edge_b[7] = '{B_UP, B_IZ, B_DN, B_DN, B_DE, B_DE, B_DE};

    initial begin
        epulses = 0;
        expect_reset_state();
        repeat (2) @(negedge clk);
        push_exp();
        check("reset");
        rst_n = 1'b1;

        // Latency: output must move on the third rising edge after the input rises.
        @(negedge clk);
        boton_arriba = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        assert (cuadro === 4'd4) else begin
            failures++; $error("FAIL lat_edge2 cuadro got=%0d exp=4", cuadro);
        end
        @(posedge clk); #1;
        checks++;
        assert (cuadro === 4'd1) else begin
            failures++; $error("FAIL lat_edge3 cuadro got=%0d exp=1", cuadro);
        end
        @(negedge clk);
        boton_arriba = 1'b0;
        repeat (3) @(negedge clk);
        cur = 4'd1;
        push_exp();
        check("move_up");

        for (int i = 0; i < 6; i++) begin
            press(5'b1 << seq_b[i], 4);
            cur = seq_c[i];
            push_exp();
            check($sformatf("seq%0d", i));
        end

        elige(1'b0, 1'b1, "elige_p2");
        elige(1'b1, 1'b0, "elige_occupied");

        // elige outranks arriba in the same cycle; occupied cell so nothing changes.
        press(5'b00011, 4);
        push_exp();
        check("elige_over_up");

        move(B_UP, "to2");
        move(B_IZ, "to1");
        move(B_IZ, "to0");
        for (int i = 0; i < 7; i++) move(edge_b[i], $sformatf("edge%0d", i));

        @(negedge clk); nuevo_juego = 1'b1;
        @(negedge clk); nuevo_juego = 1'b0;
        expect_reset_state();
        push_exp();
        check("nuevo1");

        move(B_IZ, "to3");
        press(5'b10000, 20);
        cur = mv(cur, B_DE);
        push_exp();
        check("hold_der");

        press(5'b10010, 4);
        cur = mv(cur, B_UP);
        push_exp();
        check("up_over_der");

        move(B_DN, "back4");
        move(B_DE, "to5");
        elige(1'b1, 1'b1, "elige_p1");

        // nuevo_juego held across a press: button event is overridden.
        @(negedge clk);
        nuevo_juego = 1'b1;
        boton_izq = 1'b1;
        repeat (4) @(negedge clk);
        nuevo_juego = 1'b0;
        boton_izq = 1'b0;
        repeat (3) @(negedge clk);
        expect_reset_state();
        push_exp();
        check("nuevo_over_izq");

        move(B_DE, "again5");
        elige(1'b0, 1'b1, "reselect5");

        // Reset while a button is held: one move after reset release.
        @(negedge clk);
        boton_abajo = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        expect_reset_state();
        push_exp();
        check("mid_reset");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        boton_abajo = 1'b0;
        repeat (3) @(negedge clk);
        cur = mv(cur, B_DN);
        push_exp();
        check("held_after_reset");

        checks++;
        assert (sb.size() == 0) else begin
            failures++; $error("FAIL sb_drain left=%0d exp=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
